// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: shares one single-port synchronous SRAM between the instruction (M0) and data (M1) ports.
// Define SRAM_ARB_PERF_EN to add grant/conflict performance counters.
module sram_port_arbiter #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned SRAM_LAT   = 1,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                m0_req,
  input  logic [DATA_W/8-1:0] m0_wen,
  input  logic [ADDR_W-1:0]   m0_addr,
  input  logic [DATA_W-1:0]   m0_wdata,
  output logic                m0_gnt,
  output logic                m0_rvalid,
  output logic [DATA_W-1:0]   m0_rdata,
  input  logic                m1_req,
  input  logic [DATA_W/8-1:0] m1_wen,
  input  logic [ADDR_W-1:0]   m1_addr,
  input  logic [DATA_W-1:0]   m1_wdata,
  output logic                m1_gnt,
  output logic                m1_rvalid,
  output logic [DATA_W-1:0]   m1_rdata,
  output logic                sram_en,
  output logic [DATA_W/8-1:0] sram_wen,
  output logic [ADDR_W-1:0]   sram_addr,
  output logic [DATA_W-1:0]   sram_wdata,
  input  logic [DATA_W-1:0]   sram_rdata
`ifdef SRAM_ARB_PERF_EN
  ,
  output logic [31:0]         perf_m0_gnt,
  output logic [31:0]         perf_m1_gnt,
  output logic [31:0]         perf_conflict
`endif
);

  localparam int unsigned CNT_W = 4;

  logic [CNT_W-1:0]    r_starve_cnt;
  logic [SRAM_LAT-1:0] r_tag_valid;
  logic [SRAM_LAT-1:0] r_tag_owner;
  logic                w_m0_win;
  logic                w_m1_win;
  logic                w_rd_issue;
  logic                w_ret_valid;
  logic                w_ret_owner;

  // M1 has priority unless M0 has lost STARVE_MAX times in a row
  always_comb begin
    w_m0_win = 1'b0;
    w_m1_win = 1'b0;
    if (!reset) begin
      if (m0_req && m1_req) begin
        if (r_starve_cnt == CNT_W'(STARVE_MAX)) w_m0_win = 1'b1;
        else                                    w_m1_win = 1'b1;
      end else begin
        w_m0_win = m0_req;
        w_m1_win = m1_req;
      end
    end
  end

  assign m0_gnt = w_m0_win;
  assign m1_gnt = w_m1_win;

  // Drive the SRAM with the winner's fields, all zero when idle
  always_comb begin
    sram_en    = 1'b0;
    sram_wen   = '0;
    sram_addr  = '0;
    sram_wdata = '0;
    if (w_m0_win) begin
      sram_en    = 1'b1;
      sram_wen   = m0_wen;
      sram_addr  = m0_addr;
      sram_wdata = m0_wdata;
    end else if (w_m1_win) begin
      sram_en    = 1'b1;
      sram_wen   = m1_wen;
      sram_addr  = m1_addr;
      sram_wdata = m1_wdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_starve_cnt <= '0;
    end else if (!m0_req || w_m0_win) begin
      r_starve_cnt <= '0;
    end else if (r_starve_cnt != CNT_W'(STARVE_MAX)) begin
      r_starve_cnt <= r_starve_cnt + CNT_W'(1);
    end
  end

  assign w_rd_issue = sram_en && (sram_wen == '0);

  // Read tags travel alongside the SRAM access latency
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tag_valid <= '0;
      r_tag_owner <= '0;
    end else begin
      r_tag_valid[0] <= w_rd_issue;
      r_tag_owner[0] <= w_m1_win;
      for (int i = 1; i < int'(SRAM_LAT); i++) begin
        r_tag_valid[i] <= r_tag_valid[i-1];
        r_tag_owner[i] <= r_tag_owner[i-1];
      end
    end
  end

  assign w_ret_valid = r_tag_valid[SRAM_LAT-1];
  assign w_ret_owner = r_tag_owner[SRAM_LAT-1];
  assign m0_rvalid   = w_ret_valid && !w_ret_owner;
  assign m1_rvalid   = w_ret_valid && w_ret_owner;
  assign m0_rdata    = m0_rvalid ? sram_rdata : '0;
  assign m1_rdata    = m1_rvalid ? sram_rdata : '0;

`ifdef SRAM_ARB_PERF_EN
  logic [31:0] r_perf_m0_gnt;
  logic [31:0] r_perf_m1_gnt;
  logic [31:0] r_perf_conflict;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_perf_m0_gnt   <= '0;
      r_perf_m1_gnt   <= '0;
      r_perf_conflict <= '0;
    end else begin
      if (w_m0_win)         r_perf_m0_gnt   <= r_perf_m0_gnt + 32'd1;
      if (w_m1_win)         r_perf_m1_gnt   <= r_perf_m1_gnt + 32'd1;
      if (m0_req && m1_req) r_perf_conflict <= r_perf_conflict + 32'd1;
    end
  end

  assign perf_m0_gnt   = r_perf_m0_gnt;
  assign perf_m1_gnt   = r_perf_m1_gnt;
  assign perf_conflict = r_perf_conflict;
`endif

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: three instances (SRAM_LAT 1..3) share stimulus, each with its own SRAM model.
`timescale 1ns/1ps
module tb_sram_port_arbiter;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned BW = 4;
  localparam int          NI = 3;
  localparam int          SMAX = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          m0_req, m1_req;
  logic [BW-1:0] m0_wen, m1_wen;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [DW-1:0] m0_wdata, m1_wdata;

  logic          g0 [NI];
  logic          g1 [NI];
  logic          v0 [NI];
  logic          v1 [NI];
  logic          en [NI];
  logic [DW-1:0] rd0 [NI];
  logic [DW-1:0] rd1 [NI];
  logic [DW-1:0] sw_d [NI];
  logic [BW-1:0] swen [NI];
  logic [AW-1:0] sa [NI];
`ifdef SRAM_ARB_PERF_EN
  logic [31:0]   pf0 [NI];
  logic [31:0]   pf1 [NI];
  logic [31:0]   pfc [NI];
`endif

  logic [DW-1:0] mem [256];
  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] init_word(int i);
    case (i)
      64:      return 32'hDEADBEEF;
      4:       return 32'h11110010;
      8:       return 32'h22220020;
      12:      return 32'h33330030;
      16:      return 32'hCAFE0000;
      default: return (DW'(i) * 32'h01000193) ^ 32'h5A5A0000;
    endcase
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_dut
    logic [DW-1:0] rp [4];
    sram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .SRAM_LAT(g + 1), .STARVE_MAX(SMAX)) u_dut (
      .clk(clk), .reset(reset),
      .m0_req(m0_req), .m0_wen(m0_wen), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m0_gnt(g0[g]), .m0_rvalid(v0[g]), .m0_rdata(rd0[g]),
      .m1_req(m1_req), .m1_wen(m1_wen), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m1_gnt(g1[g]), .m1_rvalid(v1[g]), .m1_rdata(rd1[g]),
      .sram_en(en[g]), .sram_wen(swen[g]), .sram_addr(sa[g]), .sram_wdata(sw_d[g]),
      .sram_rdata(rp[g])
`ifdef SRAM_ARB_PERF_EN
      , .perf_m0_gnt(pf0[g]), .perf_m1_gnt(pf1[g]), .perf_conflict(pfc[g])
`endif
    );
    // SRAM read path with latency g+1
    always @(posedge clk) begin
      rp[0] <= (en[g] && swen[g] == '0) ? mem[sa[g][9:2]] : '0;
      for (int i = 1; i < 4; i++) rp[i] <= rp[i-1];
    end
  end

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
    end else if (en[0] && swen[0] != '0) begin
      for (int b = 0; b < int'(BW); b++)
        if (swen[0][b]) mem[sa[0][9:2]][8*b +: 8] <= sw_d[0][8*b +: 8];
    end
  end

  // Reference model: grant rule, a log of accepted reads, and an abstract memory
  logic [DW-1:0] refmem [256];
  int rd_cyc [$];
  bit rd_own [$];
  logic [DW-1:0] rd_dat [$];
  int head [NI];
  int cyc = 0;
  int starve = 0;
  int n_m0 = 0, n_m1 = 0, n_cf = 0;

  function automatic int winner(logic r0, logic r1, logic rst, int s);
    if (rst || (!r0 && !r1)) return -1;
    if (r0 && r1) return (s >= SMAX) ? 0 : 1;
    return r0 ? 0 : 1;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < NI; k++) head[k] = rd_cyc.size();
      starve = 0;
      n_m0 = 0; n_m1 = 0; n_cf = 0;
      for (int i = 0; i < 256; i++) refmem[i] = init_word(i);
    end else begin
      int w;
      logic [BW-1:0] xw;
      logic [AW-1:0] xa;
      logic [DW-1:0] xd;
      w = winner(m0_req, m1_req, 1'b0, starve);
      for (int k = 0; k < NI; k++)
        if (head[k] < rd_cyc.size() && rd_cyc[head[k]] + k + 1 == cyc) head[k]++;
      if (w >= 0) begin
        xw = (w == 1) ? m1_wen : m0_wen;
        xa = (w == 1) ? m1_addr : m0_addr;
        xd = (w == 1) ? m1_wdata : m0_wdata;
        if (xw == '0) begin
          rd_cyc.push_back(cyc);
          rd_own.push_back(w == 1);
          rd_dat.push_back(refmem[xa[9:2]]);
        end else begin
          for (int b = 0; b < int'(BW); b++)
            if (xw[b]) refmem[xa[9:2]][8*b +: 8] = xd[8*b +: 8];
        end
      end
      if (m0_req && w != 0) starve = (starve < SMAX) ? starve + 1 : starve;
      else                  starve = 0;
      if (w == 0) n_m0++;
      if (w == 1) n_m1++;
      if (m0_req && m1_req) n_cf++;
      cyc++;
    end
  end

  // Every cycle: compare grants, SRAM drive and read returns of all instances
  always @(negedge clk) begin
    if (mon_en) begin
      int w;
      bit ev0, ev1;
      logic [DW-1:0] ed;
      logic [BW-1:0] xw;
      logic [AW-1:0] xa;
      logic [DW-1:0] xd;
      w  = winner(m0_req, m1_req, reset, starve);
      xw = (w == 1) ? m1_wen : (w == 0) ? m0_wen : '0;
      xa = (w == 1) ? m1_addr : (w == 0) ? m0_addr : '0;
      xd = (w == 1) ? m1_wdata : (w == 0) ? m0_wdata : '0;
      for (int k = 0; k < NI; k++) begin
        ev0 = 1'b0; ev1 = 1'b0; ed = '0;
        if (!reset && head[k] < rd_cyc.size() && rd_cyc[head[k]] + k + 1 == cyc) begin
          ev0 = !rd_own[head[k]];
          ev1 = rd_own[head[k]];
          ed  = rd_dat[head[k]];
        end
        checks++;
        if ({g0[k], g1[k]} !== {w == 0, w == 1}) begin
          errors++;
          $display("FAIL gnt lat%0d cyc %0d got %b%b want %b%b", k + 1, cyc, g0[k], g1[k], w == 0, w == 1);
        end
        checks++;
        if ({v0[k], v1[k]} !== {ev0, ev1} || rd0[k] !== (ev0 ? ed : '0) || rd1[k] !== (ev1 ? ed : '0)) begin
          errors++;
          $display("FAIL rsp lat%0d cyc %0d got v=%b%b d0=%h d1=%h want v=%b%b d=%h",
                   k + 1, cyc, v0[k], v1[k], rd0[k], rd1[k], ev0, ev1, ed);
        end
        checks++;
        if ({en[k], swen[k], sa[k], sw_d[k]} !== {w >= 0, xw, xa, xd}) begin
          errors++;
          $display("FAIL sram lat%0d cyc %0d got en=%b wen=%h a=%h d=%h want en=%b wen=%h a=%h d=%h",
                   k + 1, cyc, en[k], swen[k], sa[k], sw_d[k], w >= 0, xw, xa, xd);
        end
      end
    end
  end

  task automatic idle();
    m0_req = 1'b0; m0_wen = '0; m0_addr = '0; m0_wdata = '0;
    m1_req = 1'b0; m1_wen = '0; m1_addr = '0; m1_wdata = '0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(int n);
    idle();
    repeat (n) next_cycle();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle();
    m0_req = 1'b1; m0_addr = 32'h20;
    m1_req = 1'b1; m1_addr = 32'h10;
    mon_en = 1'b1;
    repeat (3) next_cycle();
    @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      checks++;
      if ({g0[k], g1[k], v0[k], v1[k], en[k]} !== 5'b0) begin
        errors++;
        $display("FAIL reset_outputs lat%0d got g=%b%b v=%b%b en=%b want all 0", k + 1, g0[k], g1[k], v0[k], v1[k], en[k]);
      end
    end
    next_cycle();
    reset = 1'b0;
    @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      checks++;
      if ({g0[k], g1[k]} !== 2'b01) begin
        errors++;
        $display("FAIL reset_release lat%0d got g=%b%b want 01", k + 1, g0[k], g1[k]);
      end
    end
    next_cycle();
    drain(6);
  endtask

  task automatic test_single_read();
    m0_req = 1'b1; m0_wen = '0; m0_addr = 32'h100;
    @(negedge clk);
    checks++;
    if (g0[0] !== 1'b1) begin
      errors++;
      $display("FAIL single_gnt got %b want 1", g0[0]);
    end
    next_cycle();
    idle();
    @(negedge clk);
    checks++;
    if (v0[0] !== 1'b1 || rd0[0] !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL single_rdata got v=%b d=%h want v=1 d=deadbeef", v0[0], rd0[0]);
    end
    next_cycle();
    drain(5);
  endtask

  task automatic test_starvation();
    m0_req = 1'b1; m0_addr = 32'h20;
    m1_req = 1'b1; m1_addr = 32'h10;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if ({g0[0], g1[0]} !== ((i % 5 == 4) ? 2'b10 : 2'b01)) begin
        errors++;
        $display("FAIL starve cycle %0d got g=%b%b want %b", i, g0[0], g1[0], (i % 5 == 4) ? 2'b10 : 2'b01);
      end
      next_cycle();
    end
    drain(6);
  endtask

  task automatic test_back_to_back();
    logic [1:0]    ev [8];
    logic [DW-1:0] ed [8];
    for (int i = 0; i < 8; i++) begin ev[i] = 2'b00; ed[i] = '0; end
    ev[3] = 2'b01; ed[3] = 32'h11110010;
    ev[4] = 2'b10; ed[4] = 32'h22220020;
    ev[5] = 2'b01; ed[5] = 32'h33330030;
    for (int i = 0; i < 8; i++) begin
      idle();
      if (i == 0) begin m1_req = 1'b1; m1_addr = 32'h10; end
      if (i == 1) begin m0_req = 1'b1; m0_addr = 32'h20; end
      if (i == 2) begin m1_req = 1'b1; m1_addr = 32'h30; end
      @(negedge clk);
      checks++;
      if ({v0[2], v1[2]} !== ev[i] || (rd0[2] | rd1[2]) !== ed[i]) begin
        errors++;
        $display("FAIL b2b cycle %0d got v=%b%b d=%h want v=%b d=%h", i, v0[2], v1[2], rd0[2] | rd1[2], ev[i], ed[i]);
      end
      next_cycle();
    end
    drain(2);
  endtask

  task automatic test_write();
    m1_req = 1'b1; m1_wen = 4'b0011; m1_addr = 32'h40; m1_wdata = 32'h12345678;
    @(negedge clk);
    checks++;
    if (en[0] !== 1'b1 || swen[0] !== 4'b0011 || sa[0] !== 32'h40 || sw_d[0] !== 32'h12345678) begin
      errors++;
      $display("FAIL write_drive got en=%b wen=%b a=%h d=%h want 1 0011 40 12345678", en[0], swen[0], sa[0], sw_d[0]);
    end
    next_cycle();
    idle();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      for (int k = 0; k < NI; k++) begin
        checks++;
        if ({v0[k], v1[k]} !== 2'b00) begin
          errors++;
          $display("FAIL write_no_rvalid lat%0d got v=%b%b want 00", k + 1, v0[k], v1[k]);
        end
      end
      next_cycle();
    end
    m1_req = 1'b1; m1_addr = 32'h40;
    next_cycle();
    idle();
    @(negedge clk);
    checks++;
    if (v1[0] !== 1'b1 || rd1[0][15:0] !== 16'h5678 || rd1[0] !== 32'hCAFE5678) begin
      errors++;
      $display("FAIL write_readback got v=%b d=%h want v=1 d=cafe5678", v1[0], rd1[0]);
    end
    next_cycle();
    drain(4);
  endtask

  task automatic test_reset_mid();
    m0_req = 1'b1; m0_addr = 32'h100;
    @(negedge clk);
    checks++;
    if (g0[1] !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_gnt got %b want 1", g0[1]);
    end
    next_cycle();
    idle();
    reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i == 2) reset = 1'b0;
      @(negedge clk);
      for (int k = 0; k < NI; k++) begin
        checks++;
        if (v0[k] !== 1'b0) begin
          errors++;
          $display("FAIL reset_mid_rvalid lat%0d step %0d got %b want 0", k + 1, i, v0[k]);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_random(int n);
    bit a0 = 1'b0;
    bit a1 = 1'b0;
    idle();
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (g0[0]) a0 = 1'b0;
      if (g1[0]) a1 = 1'b0;
      next_cycle();
      if (a0 && $urandom_range(0, 19) == 0) a0 = 1'b0;
      if (a1 && $urandom_range(0, 19) == 0) a1 = 1'b0;
      if (!a0 && $urandom_range(0, 2) != 0) begin
        a0 = 1'b1;
        m0_wen   = ($urandom_range(0, 1) == 1) ? BW'($urandom_range(1, 15)) : '0;
        m0_addr  = AW'($urandom_range(0, 31)) << 2;
        m0_wdata = $urandom;
      end
      if (!a1 && $urandom_range(0, 2) != 0) begin
        a1 = 1'b1;
        m1_wen   = ($urandom_range(0, 1) == 1) ? BW'($urandom_range(1, 15)) : '0;
        m1_addr  = AW'($urandom_range(0, 31)) << 2;
        m1_wdata = $urandom;
      end
      m0_req = a0;
      m1_req = a1;
    end
    drain(6);
  endtask

`ifdef SRAM_ARB_PERF_EN
  task automatic test_perf();
    @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      checks++;
      if (pf0[k] !== 32'(n_m0) || pf1[k] !== 32'(n_m1) || pfc[k] !== 32'(n_cf)) begin
        errors++;
        $display("FAIL perf lat%0d got %0d %0d %0d want %0d %0d %0d", k + 1, pf0[k], pf1[k], pfc[k], n_m0, n_m1, n_cf);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_read();
    test_starvation();
    test_back_to_back();
    test_write();
    test_reset_mid();
    test_random(3000);
`ifdef SRAM_ARB_PERF_EN
    test_perf();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
